// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a 3x3 window and |Gx|+|Gy| magnitude.
// Optional binarization against THRESHOLD when SOBEL_THRESH_EN is defined.
module sobel_edge #(
  parameter int         WIDTH     = 640,
  parameter logic [7:0] THRESHOLD = 8'd128
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [11:0] POSX,
  input  logic [11:0] POSY,
  input  logic        READY,
  output logic        RDEN,
  input  logic [7:0]  IN_R,
  input  logic [7:0]  IN_G,
  input  logic [7:0]  IN_B,
  output logic        WREN,
  output logic [7:0]  OUT_R,
  output logic [7:0]  OUT_G,
  output logic [7:0]  OUT_B
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: a pixel is accepted in any cycle where READY is high and RST is low;
  // its data arrives on IN_G one cycle later, and exactly one WREN pulse follows,
  // four cycles after acceptance, in acceptance order.
  logic        accept;
  logic        v1, v2, v3, v4;
  logic [11:0] x1, y1, x2, y2, x3, y3;
  logic [7:0]  g2, lb0_q, lb1_q;
  logic [7:0]  p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic [7:0]  out_q;
  logic [7:0]  lb0 [WIDTH];
  logic [7:0]  lb1 [WIDTH];
  logic [AW-1:0] addr;
  logic        x1_legal;

  assign RDEN     = READY;
  assign accept   = READY & ~RST;
  assign addr     = x1[AW-1:0];
  assign x1_legal = (32'(x1) < WIDTH);

  // Line buffers: read-before-write, same address; never reset.
  always_ff @(posedge CLK) begin
    if (v1 && !RST && x1_legal) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= IN_G;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      x1 <= '0; y1 <= '0; x2 <= '0; y2 <= '0; x3 <= '0; y3 <= '0;
      g2 <= '0; lb0_q <= '0; lb1_q <= '0;
      p00 <= '0; p01 <= '0; p02 <= '0;
      p10 <= '0; p11 <= '0; p12 <= '0;
      p20 <= '0; p21 <= '0; p22 <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      if (accept) begin
        x1 <= POSX;
        y1 <= POSY;
      end
      if (v1) begin
        x2    <= x1;
        y2    <= y1;
        g2    <= IN_G;
        lb0_q <= x1_legal ? lb0[addr] : 8'd0;
        lb1_q <= x1_legal ? lb1[addr] : 8'd0;
      end
      // Window moves only on accepted pixels, so gaps leave it untouched.
      if (v2) begin
        x3  <= x2;
        y3  <= y2;
        p00 <= p01; p01 <= p02; p02 <= lb1_q;
        p10 <= p11; p11 <= p12; p12 <= lb0_q;
        p20 <= p21; p21 <= p22; p22 <= g2;
      end
    end
  end

  logic [10:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx, gy;
  logic [10:0]        ax, ay;
  logic [11:0]        mag;
  logic [7:0]         sat, pix;

  always_comb begin
    gx_pos = {3'b0, p02} + {2'b0, p12, 1'b0} + {3'b0, p22};
    gx_neg = {3'b0, p00} + {2'b0, p10, 1'b0} + {3'b0, p20};
    gy_pos = {3'b0, p20} + {2'b0, p21, 1'b0} + {3'b0, p22};
    gy_neg = {3'b0, p00} + {2'b0, p01, 1'b0} + {3'b0, p02};
    gx     = signed'(gx_pos - gx_neg);
    gy     = signed'(gy_pos - gy_neg);
    ax     = gx[10] ? 11'(-gx) : 11'(gx);
    ay     = gy[10] ? 11'(-gy) : 11'(gy);
    mag    = {1'b0, ax} + {1'b0, ay};
    sat    = (mag > 12'd255) ? 8'd255 : mag[7:0];
`ifdef SOBEL_THRESH_EN
    pix    = (sat >= THRESHOLD) ? 8'd255 : 8'd0;
`else
    pix    = sat;
`endif
  end

  logic unused_in;
`ifdef SOBEL_THRESH_EN
  assign unused_in = ^{IN_R, IN_B};
`else
  assign unused_in = ^{IN_R, IN_B, THRESHOLD};
`endif

  // Border mask also hides stale columns/lines after line and frame wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q <= '0;
    end else if (v3) begin
      out_q <= (x3 < 12'd2 || y3 < 12'd2) ? 8'd0 : pix;
    end
  end

  assign WREN  = v4;
  assign OUT_R = out_q;
  assign OUT_G = out_q;
  assign OUT_B = out_q;

endmodule

// File: doc/sobel_edge.md
SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 Parameter WIDTH, default 640: active pixels per line; line buffer depth.
REQ-002 Parameter THRESHOLD, default 8'd128: binarization level, used only when SOBEL_THRESH_EN is defined.
REQ-003 CLK  input  1  sole clock; all logic on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 POSX  input  12  column of the pixel requested this cycle, 0..WIDTH-1.
REQ-006 POSY  input  12  row of the pixel requested this cycle.
REQ-007 READY  input  1  upstream has a pixel available at POSX/POSY.
REQ-008 RDEN  output  1  pixel read strobe, combinationally equal to READY.
REQ-009 IN_R, IN_G, IN_B  input  8 each  pixel data, valid the cycle after RDEN; only IN_G is used, since the grayscale stage drives equal channels.
REQ-010 WREN  output  1  output pixel valid strobe.
REQ-011 OUT_R, OUT_G, OUT_B  output  8 each  edge magnitude; all three carry the same value.

Function
REQ-012 Pipeline: RDEN at cycle t; IN_G captured at t+1; window shift at t+2; gradient sum at t+3; OUT_* and WREN registered at t+4; fixed latency of 4 cycles; one output per accepted pixel, in order.
REQ-013 Valid tracking: a 4-stage valid shift register SHALL carry RDEN, and POSX/POSY SHALL be carried alongside the data; WREN is the last stage of the valid shift register.
REQ-014 Two line buffers, each WIDTH x 8 bits, SHALL be addressed by the captured POSX. On each accepted pixel: read LB1 and LB0 at POSX; write LB1 <= LB0 data; write LB0 <= IN_G (read-before-write at the same address).
REQ-015 3x3 window: on each accepted pixel the columns shift left; the new right column = {LB1 data (row y-2), LB0 data (row y-1), IN_G (row y)}; there is no shift on idle cycles.
REQ-016 Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20), where pRC is row R, column C, and column 2 is the newest.
REQ-017 Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02).
REQ-018 Arithmetic: Gx and Gy SHALL be signed 11-bit.
REQ-019 Magnitude: |Gx| + |Gy| SHALL be unsigned 12-bit; the output SHALL saturate to 255 when the magnitude exceeds 255.
REQ-020 Output alignment: the output at stream position (POSX, POSY) is the window centred at (POSX-1, POSY-1), so the image is shifted one pixel right and down.
REQ-021 Border: the output SHALL be 0 when the carried POSX < 2 or POSY < 2.
REQ-022 Gaps: READY may drop at any cycle; window and buffer state SHALL hold; the result equals that of the gap-free stream.
REQ-023 Line wrap: the window need not be flushed at a new line because the POSX < 2 mask (REQ-021) covers the stale columns.
REQ-024 Frame wrap: the window need not be flushed at POSY = 0 because the POSY < 2 mask (REQ-021) covers the stale lines.
REQ-025 POSX >= WIDTH is an illegal input; buffer writes are suppressed for such a pixel, and the output is don't-care but WREN still follows RDEN.

Reset
REQ-026 On RST, the valid shift register, WREN, OUT_R/G/B and the window registers SHALL clear to 0 on the next edge.
REQ-027 Line buffer contents are not reset; the border mask (REQ-021) hides stale data.
REQ-028 RST mid-stream: requests in flight are dropped, with no WREN for them; the first RDEN after RST deasserts yields WREN exactly 4 cycles later.
REQ-029 RDEN follows READY during RST, but pixels requested while RST is high are not accepted.

Configuration
REQ-030 Macro SOBEL_THRESH_EN defined: OUT_* = 255 if saturated magnitude >= THRESHOLD, else 0; latency unchanged.
REQ-031 Macro SOBEL_THRESH_EN undefined: OUT_* = the saturated magnitude; the THRESHOLD parameter is ignored.

Verification
REQ-032 Flat frame, WIDTH=8, all pixels 100, continuous READY -> every WREN carries OUT=0, and WREN is RDEN delayed by 4 cycles.
REQ-033 Vertical edge, columns 0-3 = 0 and columns 4-7 = 255 -> on rows >= 2, outputs at POSX=4 and 5 = 255 (saturated), other columns = 0; rows 0-1 = 0.
REQ-034 Single bright pixel 40 at (3,3), others 0 -> output at (4,4) = 0 (centre); neighbours (3,4),(5,4),(4,3),(4,5) = 80; diagonals (3,3),(5,3),(3,5),(5,5) = 80; all others = 0.
REQ-035 REQ-033 stream with READY toggling pseudo-randomly -> output sequence identical to the continuous run.
REQ-036 RST asserted 2 cycles while 3 requests are in flight -> none of those 3 produce WREN; the next pixel's WREN appears 4 cycles after its RDEN with OUT=0 (border).
REQ-037 SOBEL_THRESH_EN defined, THRESHOLD=100, REQ-034 stimulus -> the 8 neighbours output 0 (80 < 100); repeat with pixel value 60 (magnitude 120) -> the 8 neighbours output 255.
